trivium_kiv_loader: RTL
=======================

TRIVIUM_KIV_LOADER -- requirements
Module: trivium_kiv_loader

Interface
REQ-001 Parameter: KEY_BYTES, 10, bytes per key and per IV (80 bits each).
REQ-002 Parameter: WARMUP, 1152, warm-up clocks after load (4 x 288).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ena  input  1  block enable; low freezes all state.
REQ-006 restart  input  1  synchronous request to abandon the current session and collect a new key.
REQ-007 byte_in  input  8  key/IV data byte.
REQ-008 byte_valid  input  1  byte_in holds a valid byte.
REQ-009 byte_ready  output  1  loader can accept a byte this cycle.
REQ-010 key  output  80  assembled key, to the Trivium core.
REQ-011 iv  output  80  assembled IV, to the Trivium core.
REQ-012 load  output  1  one-cycle pulse telling the core to load key/iv into its 288-bit state.
REQ-013 warm  output  1  core is clocking through warm-up; keystream is to be discarded.
REQ-014 ks_valid  output  1  warm-up complete; core keystream is usable.

Function
REQ-015 The FSM SHALL have states KEY, IV, LOAD, WARM and RUN, with KEY as the reset state.
REQ-016 A byte SHALL be accepted only when byte_valid, byte_ready and ena are all high on the same edge.
REQ-017 byte_ready SHALL equal ena AND (state is KEY or IV) AND NOT restart.
REQ-018 The n-th accepted byte (n = 0..9) in KEY SHALL be written to key[8n+7:8n]; the same mapping SHALL apply to iv in IV.
REQ-019 A 4-bit byte counter SHALL count accepted bytes; on the 10th accept it SHALL return to 0 and the FSM SHALL advance KEY->IV or IV->LOAD.
REQ-020 LOAD SHALL last exactly one enabled cycle with load=1, then go to WARM; load SHALL be 0 in every other state.
REQ-021 WARM SHALL last exactly WARMUP enabled cycles with warm=1, counted by an 11-bit counter from 0 to WARMUP-1, then go to RUN.
REQ-022 RUN SHALL hold ks_valid=1 until restart or rst; ks_valid SHALL be 0 in every other state.
REQ-023 key and iv SHALL stay stable from LOAD through RUN, and bytes presented outside KEY/IV SHALL be ignored.
REQ-024 When ena is low, FSM state, counters, key and iv SHALL hold; the load, warm and ks_valid outputs SHALL hold their values; byte_ready SHALL be 0.
REQ-025 restart=1 with ena=1 SHALL, on the next edge, put the FSM in KEY, clear both counters and set key, iv, load, warm and ks_valid to 0, from any state.
REQ-026 restart SHALL take priority over a simultaneous byte accept; that byte SHALL be dropped.
REQ-027 restart asserted mid-WARM SHALL abort warm-up with no ks_valid pulse.
REQ-028 A first-to-last latency of 2 + WARMUP cycles SHALL hold: from the edge accepting the 20th byte to the first cycle with ks_valid=1, load is high for cycle 1 and warm is high for cycles 2..1153 (uninterrupted ena).

Reset
REQ-029 rst SHALL take priority over ena and restart.
REQ-030 While rst is high, key=0, iv=0, load=0, warm=0, ks_valid=0 and byte_ready=0, and the FSM SHALL be in KEY with both counters at 0.
REQ-031 rst asserted in any state, including mid-WARM, SHALL produce the REQ-030 values on the next edge.
REQ-032 After rst deasserts with ena=1, byte_ready SHALL be 1 in the first cycle.

Verification
REQ-033 Scenario: stream bytes 0x01..0x0A then 0x11..0x1A, back to back -> key=0x0A090807060504030201, iv=0x1A191817161514131211; load for 1 cycle; warm for exactly 1152 cycles; then ks_valid=1.
REQ-034 Scenario: byte_valid toggles every other cycle and ena drops for 5 cycles during KEY and for 100 cycles during WARM -> same key/iv as REQ-033; the warm high time grows by exactly 100 cycles.
REQ-035 Scenario: restart at warm-up cycle 500 -> next cycle warm=0, key=0, byte_ready=1; no ks_valid; a fresh 20-byte session completes normally.
REQ-036 Scenario: restart on the same edge as the 7th key byte -> byte dropped, counter=0, state KEY.
REQ-037 Scenario: rst in RUN -> all outputs 0 next cycle and byte_ready=1 after release; bytes driven during WARM/RUN never alter key/iv.

Source files
------------

// File: rtl/trivium_kiv_loader.sv
// Key/IV loader and warm-up sequencer for a Trivium keystream core.
// Collects KEY_BYTES key bytes then KEY_BYTES IV bytes (little-endian byte order),
// pulses load for one cycle, holds warm high for WARMUP enabled cycles, then
// raises ks_valid until restart or rst.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   ena               - block enable; low freezes all state and registered outputs
//   restart           - abandon current session, return to key collection
//   byte_in/byte_valid/byte_ready - byte input handshake
//   key, iv           - assembled 80-bit key and IV for the core
//   load, warm, ks_valid - registered core control / status outputs
module trivium_kiv_loader #(
  parameter int unsigned KEY_BYTES = 10,
  parameter int unsigned WARMUP    = 1152
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   restart,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic [8*KEY_BYTES-1:0] key,
  output logic [8*KEY_BYTES-1:0] iv,
  output logic                   load,
  output logic                   warm,
  output logic                   ks_valid
);

  typedef enum logic [2:0] {StKey, StIv, StLoad, StWarm, StRun} state_e;

  state_e                 state_q;
  logic [3:0]             byte_cnt;
  logic [10:0]            warm_cnt;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [8*KEY_BYTES-1:0] iv_q;
  logic                   load_q;
  logic                   warm_q;
  logic                   ks_valid_q;
  logic                   accept;

  // rst is folded in so byte_ready is low for the whole reset cycle,
  // even before the state register has returned to StKey.
  assign byte_ready = !rst && ena && !restart && (state_q == StKey || state_q == StIv);
  assign accept     = byte_ready && byte_valid;

  assign key      = key_q;
  assign iv       = iv_q;
  assign load     = load_q;
  assign warm     = warm_q;
  assign ks_valid = ks_valid_q;

  always_ff @(posedge clk) begin
    if (rst || (ena && restart)) begin
      state_q    <= StKey;
      byte_cnt   <= 4'd0;
      warm_cnt   <= 11'd0;
      key_q      <= '0;
      iv_q       <= '0;
      load_q     <= 1'b0;
      warm_q     <= 1'b0;
      ks_valid_q <= 1'b0;
    end else if (ena) begin
      unique case (state_q)
        StKey, StIv: begin
          if (accept) begin
            for (int i = 0; i < KEY_BYTES; i++) begin
              if (byte_cnt == 4'(i)) begin
                if (state_q == StKey) key_q[8*i +: 8] <= byte_in;
                else                  iv_q[8*i +: 8]  <= byte_in;
              end
            end
            if (byte_cnt == 4'(KEY_BYTES - 1)) begin
              byte_cnt <= 4'd0;
              if (state_q == StKey) begin
                state_q <= StIv;
              end else begin
                state_q <= StLoad;
                load_q  <= 1'b1;
              end
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        StLoad: begin
          load_q   <= 1'b0;
          warm_q   <= 1'b1;
          warm_cnt <= 11'd0;
          state_q  <= StWarm;
        end
        StWarm: begin
          if (warm_cnt == 11'(WARMUP - 1)) begin
            warm_cnt   <= 11'd0;
            warm_q     <= 1'b0;
            ks_valid_q <= 1'b1;
            state_q    <= StRun;
          end else begin
            warm_cnt <= warm_cnt + 11'd1;
          end
        end
        StRun: begin
          ks_valid_q <= 1'b1;
        end
        default: begin
          state_q <= StKey;
        end
      endcase
    end
  end

endmodule
